// File: rtl/usb_tx_arbiter_if.sv
// Handshake bundle between the two transmit requesters, the DP/DM encoder and the arbiter.
// The arbiter connects through the slave modport; the requester/encoder side uses master.
interface usb_tx_arbiter_if;
    logic        ph_req;
    logic        nrzi_req;
    logic        rx_busy;
    logic        sent;
    logic        ph_grant;
    logic        nrzi_grant;
    logic        busy;
    logic        abort;
    logic [31:0] hold_cnt;

    modport master (
        output ph_req,
        output nrzi_req,
        output rx_busy,
        output sent,
        input  ph_grant,
        input  nrzi_grant,
        input  busy,
        input  abort,
        input  hold_cnt
    );

    modport slave (
        input  ph_req,
        input  nrzi_req,
        input  rx_busy,
        input  sent,
        output ph_grant,
        output nrzi_grant,
        output busy,
        output abort,
        output hold_cnt
    );
endinterface

// File: rtl/usb_tx_arbiter.sv
// Arbitrates the single DP/DM transmit encoder between the protocol handler and the NRZI path,
// with round-robin tie breaking, a grant timeout and a fixed inter-packet gap.
module usb_tx_arbiter #(
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 200
) (
    input  logic            clock,
    input  logic            reset_n,
    usb_tx_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_PH   = 2'd1,
        GRANT_NRZI = 2'd2,
        GAP        = 2'd3
    } state_t;

    typedef enum logic {
        WIN_PH   = 1'b0,
        WIN_NRZI = 1'b1
    } winner_t;

    localparam int          GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [31:0]      HOLD_LAST = 32'(TIMEOUT - 1);

    state_t           state;
    winner_t          last_winner;
    logic [GAP_W-1:0] gap_cnt;
    logic [31:0]      hold_cnt_q;
    logic             ph_grant_q;
    logic             nrzi_grant_q;
    logic             busy_q;
    logic             abort_q;

    // Every output is a register updated alongside the state, so none depends
    // combinationally on a request, rx_busy or sent.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            last_winner  <= WIN_NRZI;
            gap_cnt      <= '0;
            hold_cnt_q   <= '0;
            ph_grant_q   <= 1'b0;
            nrzi_grant_q <= 1'b0;
            busy_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.rx_busy) begin
                        if (bus.ph_req && (!bus.nrzi_req || last_winner == WIN_NRZI)) begin
                            state      <= GRANT_PH;
                            ph_grant_q <= 1'b1;
                            busy_q     <= 1'b1;
                            hold_cnt_q <= '0;
                            if (bus.nrzi_req) begin
                                last_winner <= WIN_PH;
                            end
                        end else if (bus.nrzi_req) begin
                            state        <= GRANT_NRZI;
                            nrzi_grant_q <= 1'b1;
                            busy_q       <= 1'b1;
                            hold_cnt_q   <= '0;
                            if (bus.ph_req) begin
                                last_winner <= WIN_NRZI;
                            end
                        end
                    end
                end
                GRANT_PH, GRANT_NRZI: begin
                    // A completed packet takes priority over a timeout landing on the same cycle.
                    if (bus.sent || hold_cnt_q == HOLD_LAST) begin
                        state        <= GAP;
                        ph_grant_q   <= 1'b0;
                        nrzi_grant_q <= 1'b0;
                        gap_cnt      <= '0;
                        abort_q      <= !bus.sent;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 32'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    ph_grant_q   <= 1'b0;
                    nrzi_grant_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ph_grant   = ph_grant_q;
    assign bus.nrzi_grant = nrzi_grant_q;
    assign bus.busy       = busy_q;
    assign bus.abort      = abort_q;
    assign bus.hold_cnt   = hold_cnt_q;

    // The encoder must never see two owners, and busy must track the state it mirrors.
    grant_exclusive: assert property (@(posedge clock) disable iff (!reset_n)
        !(ph_grant_q && nrzi_grant_q));

    busy_consistent: assert property (@(posedge clock) disable iff (!reset_n)
        busy_q == (ph_grant_q || nrzi_grant_q || state == GAP));

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Self-checking bench for usb_tx_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural ownership model.
module tb_usb_tx_arbiter;

    localparam int GAP_CYCLES = 2;
    localparam int TIMEOUT    = 200;

    logic clock;
    logic reset_n;

    usb_tx_arbiter_if bus_if ();

    usb_tx_arbiter #(
        .GAP_CYCLES(GAP_CYCLES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus_if)
    );

    int tests_run;
    int tests_failed;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: who owns the encoder, how many gap cycles remain,
    // how long the current owner has held it, and who won the last tie.
    int          m_owner;
    int          m_gap_left;
    int          m_hold;
    int          m_last_tie;
    logic        m_abort;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_owner    = 0;
            m_gap_left = 0;
            m_hold     = 0;
            m_last_tie = 2;
            m_abort    = 1'b0;
        end else begin
            m_abort = 1'b0;
            if (m_owner != 0) begin
                if (bus_if.sent) begin
                    m_owner    = 0;
                    m_gap_left = GAP_CYCLES;
                end else if (m_hold == TIMEOUT - 1) begin
                    m_owner    = 0;
                    m_gap_left = GAP_CYCLES;
                    m_abort    = 1'b1;
                end else begin
                    m_hold = m_hold + 1;
                end
            end else if (m_gap_left > 0) begin
                m_gap_left = m_gap_left - 1;
            end else if (!bus_if.rx_busy) begin
                if (bus_if.ph_req && bus_if.nrzi_req) begin
                    m_owner    = (m_last_tie == 1) ? 2 : 1;
                    m_last_tie = m_owner;
                    m_hold     = 0;
                end else if (bus_if.ph_req) begin
                    m_owner = 1;
                    m_hold  = 0;
                end else if (bus_if.nrzi_req) begin
                    m_owner = 2;
                    m_hold  = 0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ph, input logic nrzi, input logic rxb,
                                 input logic snt);
        bus_if.ph_req   = ph;
        bus_if.nrzi_req = nrzi;
        bus_if.rx_busy  = rxb;
        bus_if.sent     = snt;
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Compare every cycle, away from the active edge, against the model.
    always @(negedge clock) begin
        checkOutput("cmp_ph_grant",   32'(bus_if.ph_grant),   32'(m_owner == 1));
        checkOutput("cmp_nrzi_grant", 32'(bus_if.nrzi_grant), 32'(m_owner == 2));
        checkOutput("cmp_busy",       32'(bus_if.busy),       32'(m_owner != 0 || m_gap_left > 0));
        checkOutput("cmp_abort",      32'(bus_if.abort),      32'(m_abort));
        checkOutput("cmp_hold_cnt",   bus_if.hold_cnt,        32'(m_hold));
        checkOutput("cmp_exclusive",  32'(bus_if.ph_grant & bus_if.nrzi_grant), 32'd0);
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();

        checkOutput("rst_ph_grant", 32'(bus_if.ph_grant), 32'd0);
        checkOutput("rst_busy",     32'(bus_if.busy),     32'd0);
        checkOutput("rst_abort",    32'(bus_if.abort),    32'd0);
        checkOutput("rst_hold_cnt", bus_if.hold_cnt,      32'd0);
        reset_n = 1'b1;
        tick();

        // Single PH request, sent after a few cycles, then the two-cycle gap.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("t1_grant_latency", 32'(bus_if.ph_grant), 32'd1);
        checkOutput("t1_hold_entry",    bus_if.hold_cnt,      32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) tick();
        checkOutput("t1_hold_count", bus_if.hold_cnt,      32'd6);
        checkOutput("t1_grant_held", 32'(bus_if.ph_grant), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_grant_drop", 32'(bus_if.ph_grant), 32'd0);
        checkOutput("t1_gap1_busy",  32'(bus_if.busy),     32'd1);
        checkOutput("t1_hold_frozen", bus_if.hold_cnt,     32'd6);
        tick();
        checkOutput("t1_gap2_busy",  32'(bus_if.busy),     32'd1);
        tick();
        checkOutput("t1_idle_busy",  32'(bus_if.busy),     32'd0);

        // Both requesting through three packets: PH, NRZI, PH.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        for (int p = 0; p < 3; p++) begin
            checkOutput("t2_ph_grant",   32'(bus_if.ph_grant),   32'(p % 2 == 0));
            checkOutput("t2_nrzi_grant", 32'(bus_if.nrzi_grant), 32'(p % 2 == 1));
            repeat (3) tick();
            applyStimulus(p != 2, p != 2, 1'b0, 1'b1);
            tick();
            applyStimulus(p != 2, p != 2, 1'b0, 1'b0);
            checkOutput("t2_gap_no_grant", 32'(bus_if.ph_grant | bus_if.nrzi_grant), 32'd0);
            tick();
            checkOutput("t2_gap_busy", 32'(bus_if.busy), 32'd1);
            tick();
            checkOutput("t2_idle_no_grant", 32'(bus_if.ph_grant | bus_if.nrzi_grant), 32'd0);
            checkOutput("t2_idle_busy",     32'(bus_if.busy), 32'd0);
            if (p != 2) tick();
        end

        // rx_busy blocks the grant; release gives NRZI one cycle later.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 21; c++) begin
            tick();
            checkOutput("t3_blocked", 32'(bus_if.nrzi_grant | bus_if.busy), 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("t3_nrzi_grant", 32'(bus_if.nrzi_grant), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Never send: the NRZI grant times out with a single abort pulse.
        repeat (199) tick();
        checkOutput("t4_hold_last",  bus_if.hold_cnt,        32'd199);
        checkOutput("t4_still_held", 32'(bus_if.nrzi_grant), 32'd1);
        checkOutput("t4_no_abort_yet", 32'(bus_if.abort),    32'd0);
        tick();
        checkOutput("t4_grant_drop", 32'(bus_if.nrzi_grant), 32'd0);
        checkOutput("t4_abort",      32'(bus_if.abort),      32'd1);
        checkOutput("t4_hold_frozen", bus_if.hold_cnt,       32'd199);
        tick();
        checkOutput("t4_abort_clear", 32'(bus_if.abort), 32'd0);
        checkOutput("t4_gap_busy",    32'(bus_if.busy),  32'd1);
        tick();
        checkOutput("t4_idle", 32'(bus_if.busy), 32'd0);

        // sent coincides with the final timeout cycle: no abort.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("t5_ph_grant", 32'(bus_if.ph_grant), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (199) tick();
        checkOutput("t5_hold_last", bus_if.hold_cnt, 32'd199);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_grant_drop", 32'(bus_if.ph_grant), 32'd0);
        checkOutput("t5_no_abort",   32'(bus_if.abort),    32'd0);
        repeat (2) tick();
        checkOutput("t5_idle", 32'(bus_if.busy), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_stray_sent_busy", 32'(bus_if.busy), 32'd0);
        checkOutput("t5_stray_sent_hold", bus_if.hold_cnt,   32'd199);

        // Asynchronous reset in the middle of a PH grant.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (50) tick();
        checkOutput("t6_hold_mid", bus_if.hold_cnt, 32'd50);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_async_ph_grant", 32'(bus_if.ph_grant), 32'd0);
        checkOutput("t6_async_busy",     32'(bus_if.busy),     32'd0);
        checkOutput("t6_async_hold",     bus_if.hold_cnt,      32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("t6_tie_to_ph",   32'(bus_if.ph_grant),   32'd1);
        checkOutput("t6_tie_no_nrzi", 32'(bus_if.nrzi_grant), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        // Randomized traffic; a quiet stretch lets timeouts happen too.
        for (int c = 0; c < 3000; c++) begin
            logic snt;
            snt = (c >= 1200 && c < 1500) ? 1'b0 : ($urandom_range(0, 24) == 0);
            applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 4) == 0, snt);
            if (c == 2200) begin
                #3;
                reset_n = 1'b0;
                tick();
                tick();
                reset_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
